// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use hazard detection, bubble insertion, branch flush,
// WB-to-ID write-through bypass and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IF_ID_valid,
    input  logic [XLEN-1:0]  IF_ID_pc,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       IF_ID_rd,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic [XLEN-1:0]  IF_ID_imm,
    input  logic [7:0]       IF_ID_ctrl,
    input  logic [3:0]       IF_ID_aluOp,
    input  logic             MEM_WB_regWrite,
    input  logic [4:0]       MEM_WB_rd,
    input  logic [XLEN-1:0]  MEM_WB_wdata,
    input  logic             branch_flush,
    input  logic             ex_hold,
    output logic             ID_EX_valid,
    output logic [XLEN-1:0]  ID_EX_pc,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [XLEN-1:0]  ID_EX_rs1_data,
    output logic [XLEN-1:0]  ID_EX_rs2_data,
    output logic [XLEN-1:0]  ID_EX_imm,
    output logic [7:0]       ID_EX_ctrl,
    output logic [3:0]       ID_EX_aluOp,
    output logic             stall_if_id,
    output logic [CNT_W-1:0] bubble_count
);
    localparam int MEMREAD_BIT = 6;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [7:0]      ctrl;
        logic [3:0]      alu_op;
    } id_ex_t;

    id_ex_t           stage_q, stage_d, load_pkt;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             hazard, bubble, byp_rs1, byp_rs2;

    always_comb begin
        hazard = stage_q.valid && stage_q.ctrl[MEMREAD_BIT] && (stage_q.rd != 5'd0) &&
                 IF_ID_valid &&
                 ((IF_ID_uses_rs1 && (IF_ID_rs1 == stage_q.rd)) ||
                  (IF_ID_uses_rs2 && (IF_ID_rs2 == stage_q.rd)));
    end

    // Reset gating keeps the stall low while the stage is held in reset, even with ex_hold up.
    assign stall_if_id = rst_n && ((hazard && !branch_flush) || ex_hold);

    // A write to x0 never bypasses; the register file already returns 0 for it.
    assign byp_rs1 = MEM_WB_regWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == IF_ID_rs1);
    assign byp_rs2 = MEM_WB_regWrite && (MEM_WB_rd != 5'd0) && (MEM_WB_rd == IF_ID_rs2);

    always_comb begin
        load_pkt          = '0;
        load_pkt.valid    = IF_ID_valid;
        load_pkt.pc       = IF_ID_pc;
        load_pkt.rs1      = IF_ID_rs1;
        load_pkt.rs2      = IF_ID_rs2;
        load_pkt.rd       = IF_ID_rd;
        load_pkt.rs1_data = byp_rs1 ? MEM_WB_wdata : rf_rs1_data;
        load_pkt.rs2_data = byp_rs2 ? MEM_WB_wdata : rf_rs2_data;
        load_pkt.imm      = IF_ID_imm;
        load_pkt.ctrl     = IF_ID_valid ? IF_ID_ctrl  : 8'd0;
        load_pkt.alu_op   = IF_ID_valid ? IF_ID_aluOp : 4'd0;
    end

    always_comb begin
        bubble       = branch_flush || (!ex_hold && hazard);
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble) begin
            stage_d = '0;
            if (bubble_cnt_q != {CNT_W{1'b1}})
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (!ex_hold) begin
            stage_d = load_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ID_EX_valid    = stage_q.valid;
    assign ID_EX_pc       = stage_q.pc;
    assign ID_EX_rs1      = stage_q.rs1;
    assign ID_EX_rs2      = stage_q.rs2;
    assign ID_EX_rd       = stage_q.rd;
    assign ID_EX_rs1_data = stage_q.rs1_data;
    assign ID_EX_rs2_data = stage_q.rs2_data;
    assign ID_EX_imm      = stage_q.imm;
    assign ID_EX_ctrl     = stage_q.ctrl;
    assign ID_EX_aluOp    = stage_q.alu_op;
    assign bubble_count   = bubble_cnt_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage RV32I pipeline. It captures decoded operands and control from IF/ID and holds them for EX, where they feed the forwarding logic and the ALU operand muxes. It also detects load-use hazards, inserts bubbles, applies branch flushes and does a WB-to-ID register-file write-through bypass. A saturating counter tracks the number of bubbles inserted.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
IF_ID_valid  in  1  IF/ID holds a real instruction
IF_ID_pc  in  XLEN  instruction PC
IF_ID_rs1  in  5  source register 1
IF_ID_rs2  in  5  source register 2
IF_ID_rd  in  5  destination register
IF_ID_uses_rs1  in  1  instruction reads rs1
IF_ID_uses_rs2  in  1  instruction reads rs2
rf_rs1_data  in  XLEN  register-file read port 1
rf_rs2_data  in  XLEN  register-file read port 2
IF_ID_imm  in  XLEN  decoded immediate
IF_ID_ctrl  in  8  {regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, rsvd}
IF_ID_aluOp  in  4  ALU operation
MEM_WB_regWrite  in  1  WB writing register file this cycle
MEM_WB_rd  in  5  WB destination
MEM_WB_wdata  in  XLEN  WB write data
branch_flush  in  1  EX resolved taken branch/jump
ex_hold  in  1  downstream stall; freeze ID/EX
ID_EX_valid  out  1  registered valid
ID_EX_pc  out  XLEN  registered PC
ID_EX_rs1  out  5  registered rs1 (to forwarding)
ID_EX_rs2  out  5  registered rs2 (to forwarding)
ID_EX_rd  out  5  registered rd
ID_EX_rs1_data  out  XLEN  registered operand 1
ID_EX_rs2_data  out  XLEN  registered operand 2
ID_EX_imm  out  XLEN  registered immediate
ID_EX_ctrl  out  8  registered control
ID_EX_aluOp  out  4  registered ALU op
stall_if_id  out  1  combinational: hold PC and IF/ID
bubble_count  out  CNT_W  bubbles inserted, saturating

Behaviour:
- Reset (rst_n low, asynchronous): all ID_EX_* outputs 0, ID_EX_valid=0, bubble_count=0. stall_if_id is 0 while in reset.
- Load-use hazard (combinational) holds when all of these are true:
  - ID_EX_valid, ID_EX_ctrl.memRead, ID_EX_rd!=0 and IF_ID_valid;
  - and either (IF_ID_uses_rs1 && IF_ID_rs1==ID_EX_rd) or (IF_ID_uses_rs2 && IF_ID_rs2==ID_EX_rd).
- stall_if_id = (hazard && !branch_flush) || ex_hold.
- Per rising edge, priority order:
  1. branch_flush: load bubble (valid=0, ctrl=0, aluOp=0; other fields don't-care, implemented as 0). Flush wins over ex_hold.
  2. ex_hold: all ID_EX_* registers keep their value.
  3. hazard: load bubble. IF/ID is held externally, so the consumer re-presents the same instruction next cycle.
  4. Otherwise: load all IF_ID_* fields. valid = IF_ID_valid. When IF_ID_valid=0, ctrl and aluOp load as 0.
- Write-through bypass on operand capture:
  - If MEM_WB_regWrite && MEM_WB_rd!=0 && MEM_WB_rd==IF_ID_rs1, ID_EX_rs1_data takes MEM_WB_wdata instead of rf_rs1_data. Same rule for rs2.
  - rd==x0 never bypasses; x0 reads take rf data, which is 0.
- Latency: one cycle IF/ID→ID/EX. A load-use costs exactly one bubble. The second attempt does not re-stall, because ID_EX then holds the bubble (valid=0).
- bubble_count increments by 1 on every edge that loads a bubble from rule 1 or rule 3 while rst_n is high. It saturates at 2^CNT_W−1 and never wraps.
- A bubble load always clears ID_EX_ctrl.regWrite and memWrite, so no architectural side effects reach EX.
- Reset asserted mid-stall: registers clear immediately; after release the pipeline resumes from the re-presented IF/ID contents.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with valid IF/ID → all outputs 0 immediately; after release, first edge loads IF/ID normally.
- Load-use: `lw x5` then `add x6,x5,x7` (uses_rs1=1) → stall_if_id=1 for one cycle; next edge ID_EX_valid=0, ctrl=0, bubble_count=1; following edge the add loads with ID_EX_rs1=5.
- No false stall: lw x5, then `lui x5` (uses_rs1=uses_rs2=0) → stall_if_id=0, no bubble. Same result for lw x0 followed by a consumer of x0.
- Flush vs hazard: a load-use hazard and branch_flush=1 in the same cycle → stall_if_id=0, bubble loaded, bubble_count +1 (not +2).
- Bypass: MEM_WB writes x9=0xDEADBEEF in the same cycle that IF_ID_rs2=9 and rf_rs2_data=0x0 → ID_EX_rs2_data=0xDEADBEEF. With MEM_WB_rd=0 → rf data taken.
- Hold and saturation: ex_hold=1 for 3 cycles → outputs frozen and stall_if_id=1. With CNT_W=2, force 5 bubbles → bubble_count stops at 3.
